uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Synchronous first-word-fall-through FIFO that buffers bytes for the UART transmitter.
//  Producer side: wr_en/wr_data. Consumer side: tx_start = "not empty", tx_data = head word,
//  tx_done = pop pulse from the transmitter on stop-bit completion.
//  Sits directly upstream of the UART transmitter in the UART system.
// PARAMETERS
//  DBITS      8   data word width; must match transmitter DBITS
//  ADDR_BITS  4   log2(depth); depth = 2**ADDR_BITS = 16 words
//  AF_LEVEL   12  almost_full threshold, in words (1..2**ADDR_BITS)
// PORTS
//  clk_100MHz   in   1            system clock, all logic on rising edge
//  reset_n      in   1            asynchronous, active-low reset
//  wr_en        in   1            write request, 1 cycle = 1 word
//  wr_data      in   DBITS        word to enqueue
//  tx_done      in   1            pop request (1-cycle pulse from transmitter)
//  tx_start     out  1            FIFO not empty; drives transmitter tx_start
//  tx_data      out  DBITS        head word (valid while tx_start=1, else 0)
//  full         out  1            count == 2**ADDR_BITS
//  almost_full  out  1            count >= AF_LEVEL
//  count        out  ADDR_BITS+1  words held, 0..2**ADDR_BITS
// BEHAVIOUR
//  - Reset (async assert, sync release): wr_ptr=rd_ptr=0, count=0, tx_start=0, full=0,
//    almost_full=0, tx_data=0. Storage contents are not cleared.
//  - Pointers are ADDR_BITS wide and wrap modulo depth. count is a registered
//    up/down counter; full, almost_full and tx_start decode from registered count.
//  - Write accepted when wr_en && (!full || pop_ok). Word lands at mem[wr_ptr];
//    wr_ptr++ on the same edge.
//  - Pop accepted when tx_done && tx_start (pop_ok); rd_ptr++ on the same edge.
//  - Count update: +1 write only, -1 pop only, unchanged when both or neither.
//  - Latency: a write into an empty FIFO at edge N gives tx_start=1 and tx_data=word
//    from edge N onward (first-word fall-through, 1 cycle write-to-visible).
//  - After a pop at edge N, tx_data shows the next word at edge N. tx_start drops
//    at edge N if that pop emptied the FIFO.
//  - tx_data = mem[rd_ptr] when count!=0, else 0 (combinational mux on registered state).
//  - Full + wr_en without pop: write dropped, no pointer or count change.
//  - Full + wr_en + pop: both accepted; count stays at depth.
//  - Empty + tx_done: ignored.
//  - Empty + wr_en + tx_done: write accepted, pop ignored, count becomes 1.
//  - Reset asserted mid-operation: all pointers and flags return to their reset values
//    immediately. Buffered words are lost.
//  - The transmitter latches the head only in its idle state, so the head must stay
//    stable until tx_done. The FIFO guarantees this because only a pop moves rd_ptr.
// CONFIGURATION
//  UART_TX_FIFO_ERR_EN defined:
//    - Adds input err_clr (1 bit) and sticky outputs overflow and underflow (1 bit each).
//    - overflow sets on a dropped write (full && wr_en && !pop_ok).
//    - underflow sets on tx_done while empty.
//    - Both flags reset to 0 and clear on err_clr. If set and clear occur in the same
//      cycle, set wins.
//  UART_TX_FIFO_ERR_EN undefined: those ports and that logic are absent; drops and
//    underflows are silent.
// TESTING
//  1. Release reset, idle 5 cycles -> tx_start=0, count=0, full=0, tx_data=0.
//  2. Write 0xA5 once -> next cycle tx_start=1, tx_data=0xA5, count=1.
//     Pulse tx_done -> tx_start=0, count=0.
//  3. Write 0x00..0x0F (16 words) -> full=1, count=16, almost_full high from the
//     12th write. Write 0xFF -> dropped, count=16 (overflow=1 if ERR_EN).
//     Pop 16 times -> data read back 0x00..0x0F in order.
//  4. With FIFO full, assert wr_en=1 (0x55) and tx_done=1 in the same cycle ->
//     count stays 16, head advances. Fill/drain 40 words to verify pointer wrap.
//  5. Empty FIFO: wr_en(0x3C) + tx_done together -> count=1, tx_data=0x3C
//     (underflow=1 if ERR_EN); err_clr -> flags return to 0.
//  6. With the transmitter attached at 9600 baud, write "HI" -> tx line shows two
//     10-bit frames 0x48, 0x49 back-to-back. Assert reset_n=0 mid-frame with 3 words
//     queued -> count=0 and tx_start=0 immediately.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: first-word-fall-through byte FIFO feeding the UART transmitter.
// Optional sticky error flags are enabled with `define UART_TX_FIFO_ERR_EN.
module uart_tx_fifo #(
  parameter int DBITS     = 8,
  parameter int ADDR_BITS = 4,
  parameter int AF_LEVEL  = 12
) (
  input  logic                 clk_100MHz,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [DBITS-1:0]     wr_data,
  input  logic                 tx_done,
`ifdef UART_TX_FIFO_ERR_EN
  input  logic                 err_clr,
  output logic                 overflow,
  output logic                 underflow,
`endif
  output logic                 tx_start,
  output logic [DBITS-1:0]     tx_data,
  output logic                 full,
  output logic                 almost_full,
  output logic [ADDR_BITS:0]   count
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] C_DEPTH = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS:0] C_AF    = (ADDR_BITS+1)'(AF_LEVEL);

  logic [DBITS-1:0]     r_mem [DEPTH];
  logic [ADDR_BITS-1:0] r_wr_ptr;
  logic [ADDR_BITS-1:0] r_rd_ptr;
  logic [ADDR_BITS:0]   r_count;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  // Status decode straight from the registered count.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == C_DEPTH);

  // A pop needs data; a push needs room, or a same-cycle pop that frees a slot.
  assign w_pop  = tx_done && !w_empty;
  assign w_push = wr_en && (!w_full || w_pop);

  // Storage is deliberately not reset; only pointers define valid content.
  always_ff @(posedge clk_100MHz) begin
    if (w_push)
      r_mem[r_wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally at depth; count tracks net push/pop.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef UART_TX_FIFO_ERR_EN
  logic r_overflow;
  logic r_underflow;
  logic w_ovf_set;
  logic w_udf_set;

  assign w_ovf_set = wr_en && w_full && !w_pop;
  assign w_udf_set = tx_done && w_empty;

  // Sticky error flags; a new event beats a simultaneous clear.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_set)
        r_overflow <= 1'b1;
      else if (err_clr)
        r_overflow <= 1'b0;
      if (w_udf_set)
        r_underflow <= 1'b1;
      else if (err_clr)
        r_underflow <= 1'b0;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

  // Head word is forced to zero while empty so stale storage never leaks out.
  always_comb begin
    tx_data = '0;
    if (!w_empty)
      tx_data = r_mem[r_rd_ptr];
  end

  assign tx_start    = !w_empty;
  assign full        = w_full;
  assign almost_full = (r_count >= C_AF);
  assign count       = r_count;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed and random checks of uart_tx_fifo
// against a queue-based reference model.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AF    = 12;

  logic       clk_100MHz = 1'b0;
  logic       reset_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       tx_done;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       full;
  logic       almost_full;
  logic [4:0] count;
`ifdef UART_TX_FIFO_ERR_EN
  logic       err_clr;
  logic       overflow;
  logic       underflow;
  bit         m_ovf;
  bit         m_udf;
`endif

  int nvec = 0;
  int nerr = 0;
  byte unsigned q[$];

  uart_tx_fifo #(.DBITS(8), .ADDR_BITS(4), .AF_LEVEL(AF)) dut (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .tx_done    (tx_done),
`ifdef UART_TX_FIFO_ERR_EN
    .err_clr    (err_clr),
    .overflow   (overflow),
    .underflow  (underflow),
`endif
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .full       (full),
    .almost_full(almost_full),
    .count      (count)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_all();
    int n;
    n = q.size();
    chk("tx_start", 32'(tx_start), 32'(n != 0));
    chk("tx_data", 32'(tx_data), (n != 0) ? 32'(q[0]) : 32'd0);
    chk("count", 32'(count), 32'(n));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(n >= AF));
`ifdef UART_TX_FIFO_ERR_EN
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_udf));
`endif
  endtask

  // one clock with the given inputs; model advances, then outputs are checked
  task automatic step(input bit we, input byte unsigned wd, input bit done,
                      input bit clr = 1'b0);
    bit pop_ok;
    bit wr_ok;
    wr_en   = we;
    wr_data = wd;
    tx_done = done;
`ifdef UART_TX_FIFO_ERR_EN
    err_clr = clr;
`endif
    @(posedge clk_100MHz);
    pop_ok = done && (q.size() > 0);
    wr_ok  = we && ((q.size() < DEPTH) || pop_ok);
`ifdef UART_TX_FIFO_ERR_EN
    if (we && !wr_ok) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (done && q.size() == 0) m_udf = 1'b1;
    else if (clr) m_udf = 1'b0;
`else
    if (clr) begin end
`endif
    if (pop_ok) void'(q.pop_front());
    if (wr_ok) q.push_back(wd);
    #1;
    chk_all();
    wr_en   = 1'b0;
    tx_done = 1'b0;
`ifdef UART_TX_FIFO_ERR_EN
    err_clr = 1'b0;
`endif
  endtask

  initial begin
    byte unsigned d;
    reset_n = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    tx_done = 1'b0;
`ifdef UART_TX_FIFO_ERR_EN
    err_clr = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
`endif
    repeat (3) @(posedge clk_100MHz);
    #2 reset_n = 1'b1;

    // idle after reset
    for (int i = 0; i < 5; i++) step(0, 8'h00, 0);
    chk("rst_count", 32'(count), 32'd0);

    // single word in and out
    step(1, 8'hA5, 0);
    chk("a5_data", 32'(tx_data), 32'hA5);
    step(0, 8'h00, 1);
    chk("a5_popped", 32'(tx_start), 32'd0);

    // fill to full, watch almost_full edge
    for (int i = 0; i < 16; i++) begin
      step(1, 8'(i), 0);
      chk("af_edge", 32'(almost_full), 32'(i >= AF - 1));
    end
    chk("full_set", 32'(full), 32'd1);
    step(1, 8'hFF, 0);
    chk("drop_cnt", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk("rd_order", 32'(tx_data), 32'(i));
      step(0, 8'h00, 1);
    end

    // full with simultaneous push and pop
    for (int i = 0; i < 16; i++) step(1, 8'(8'h80 + i), 0);
    step(1, 8'h55, 1);
    chk("fullpp_cnt", 32'(count), 32'd16);
    chk("fullpp_head", 32'(tx_data), 32'h81);
    while (q.size() > 0) step(0, 8'h00, 1);

    // 40 words through to exercise pointer wrap
    for (int i = 0; i < 40; i++) begin
      step(1, 8'(8'h20 + i), 0);
      if (i % 3 == 2) step(0, 8'h00, 1);
    end
    while (q.size() > 0) step(0, 8'h00, 1);

    // empty with push and pop together; then error clear
    step(0, 8'h00, 1);
    step(1, 8'h3C, 1);
    chk("emptypp_cnt", 32'(count), 32'd1);
    chk("emptypp_data", 32'(tx_data), 32'h3C);
    step(0, 8'h00, 0, 1'b1);
    step(0, 8'h00, 1);

    // random traffic with phase-dependent bias
    for (int ph = 0; ph < 8; ph++) begin
      int pw;
      int pd;
      pw = (ph % 2 == 0) ? 80 : 25;
      pd = (ph % 2 == 0) ? 25 : 80;
      for (int i = 0; i < 200; i++) begin
        d = 8'($urandom);
        step(($urandom_range(99) < pw), d, ($urandom_range(99) < pd),
             ($urandom_range(99) < 5));
      end
    end

    // reset mid-operation with 3 words queued
    while (q.size() > 0) step(0, 8'h00, 1);
    step(1, 8'h48, 0);
    step(1, 8'h49, 0);
    step(1, 8'h0A, 0);
    #2 reset_n = 1'b0;
    #1;
    q.delete();
`ifdef UART_TX_FIFO_ERR_EN
    m_ovf = 1'b0;
    m_udf = 1'b0;
`endif
    chk("rst_async_cnt", 32'(count), 32'd0);
    chk("rst_async_start", 32'(tx_start), 32'd0);
    chk("rst_async_data", 32'(tx_data), 32'd0);
    @(posedge clk_100MHz);
    #2 reset_n = 1'b1;
    step(1, 8'h77, 0);
    step(0, 8'h00, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
